// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue stage.
//   DEF_WIDTH / DEF_DEPTH : default operand width and request FIFO depth
//   OP_W                  : operation encoding width
//   alu_op_e              : ALU operation enum
//   alu_io_t              : ALU_IO request (operands, carry-in, operation)
// Optional feature macro: ALU_ISSUE_CHAIN_EN adds a 1-bit 'chain' field to
// alu_io_t so a request can take its carry-in from the previous result.
package alu_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,   // a + ~b + cin: cin=1 gives a plain a-b, carry=1 means no borrow
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_PASS = 3'd5
    } alu_op_e;

    typedef struct packed {
`ifdef ALU_ISSUE_CHAIN_EN
        logic                 chain;
`endif
        alu_op_e              op;
        logic                 cin;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } alu_io_t;
endpackage

// File: rtl/alu_8bit.sv
// alu_8bit: combinational ripple-carry ALU.
//   a, b      : operands (WIDTH bits)
//   cin       : carry-in for ADD/SUB
//   op        : operation (alu_op_e)
//   result    : WIDTH-bit result
//   carry_out : ripple carry out for ADD/SUB, 0 for logic ops
module alu_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = '0;
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b_eff[i] ^ c[i];
            c[i+1]   = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
        end
        result    = sum;
        carry_out = c[WIDTH];
        case (op)
            OP_AND:  begin result = a & b; carry_out = 1'b0; end
            OP_OR:   begin result = a | b; carry_out = 1'b0; end
            OP_XOR:  begin result = a ^ b; carry_out = 1'b0; end
            OP_PASS: begin result = a;     carry_out = 1'b0; end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: DEPTH-entry FIFO of alu_io_t requests.
//   push/wdata : write wdata at the tail (caller guarantees !full)
//   pop        : drop the head (caller guarantees !empty)
//   rdata      : current head entry
//   full/empty : occupancy flags decoded from count
//   count      : occupied entries, 0..DEPTH
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  alu_io_t          wdata,
    output alu_io_t          rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    alu_io_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally (DEPTH is a power of two); count disambiguates full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffered issue stage in front of alu_8bit.
//   in_valid/in_ready/in_req     : request handshake (in_ready from state only)
//   out_valid/out_ready          : result slot handshake
//   out_result/out_carry         : registered ALU result and carry-out
//   fifo_count                   : occupied request FIFO entries (debug)
// Optional feature macro: ALU_ISSUE_CHAIN_EN -- requests with chain=1 take
// their carry-in from the carry of the previously issued request.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_io_t          in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic [CNT_W-1:0] fifo_count
);
    logic             push;
    logic             issue;
    logic             full;
    logic             empty;
    alu_io_t          head;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    // No bypass in either direction: a freed entry is only usable next cycle,
    // and a pushed request must sit in the FIFO for a cycle before issue.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign issue    = !empty && (!out_valid || out_ready);

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (issue),
        .wdata (in_req),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

`ifdef ALU_ISSUE_CHAIN_EN
    // Carry of the last issued request, feeding multi-byte add/sub chains.
    logic chain_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     chain_carry <= 1'b0;
        else if (issue) chain_carry <= alu_carry;
    end

    assign alu_cin = head.chain ? chain_carry : head.cin;
`else
    assign alu_cin = head.cin;
`endif

    alu_8bit #(.WIDTH(WIDTH)) u_alu (
        .a         (head.a[WIDTH-1:0]),
        .b         (head.b[WIDTH-1:0]),
        .cin       (alu_cin),
        .op        (head.op),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // Output slot. When not issuing, a taken result can only mean the FIFO
    // is empty, so the slot simply empties; data registers hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_carry  <= alu_carry;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule
